// File: rtl/wb_bar_graph_pkg.sv
// Shared constants for the LED bar graph Wishbone slave: register indices,
// pattern modes and the CTRL register layout.
package wb_bar_graph_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_DATA     = 2'd1;
  localparam logic [1:0] REG_PRESCALE = 2'd2;
  localparam logic [1:0] REG_BRIGHT   = 2'd3;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_LEVEL  = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_WIDTH    = 3;

  // Packed so that en lands on bit 0 and mode on bits [2:1].
  typedef struct packed {
    mode_e mode;
    logic  en;
  } ctrl_t;

  localparam int         PWM_PERIOD   = 15;
  localparam logic [3:0] BRIGHT_RESET = 4'hF;

endpackage

// File: rtl/bar_graph_ticker.sv
// Prescaler: counts 0..period_i and pulses tick_o on the terminal count,
// giving one tick every period_i+1 clocks while enabled.
module bar_graph_ticker #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] period_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             at_end;

  // >= rather than == keeps the counter bounded if the period shrinks under it.
  assign at_end = (cnt_q >= period_i);
  assign tick_o = enable_i & ~clear_i & at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_bar_graph.sv
// Wishbone slave driving an LED bar graph in direct, level-meter or scroll mode.
// Optional macro BAR_GRAPH_PWM_EN adds a BRIGHT register and 15-step PWM dimming.
module wb_bar_graph
  import wb_bar_graph_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LED_COUNT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wbs_address,
  input  logic [DATA_WIDTH-1:0] wbs_writedata,
  output logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_write,
  input  logic                  wbs_cycle,
  input  logic                  wbs_strobe,
  output logic                  wbs_ack,
  output logic [LED_COUNT-1:0]  led
);

  logic                  ack_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_mux;
  ctrl_t                 ctrl_q;
  logic [DATA_WIDTH-1:0] data_q, prescale_q;
  logic [LED_COUNT-1:0]  pattern_q, pattern_d;
  logic [LED_COUNT-1:0]  led_q, led_d;
  logic [LED_COUNT-1:0]  level_mask, base_pat;
  logic                  scroll_q;

  logic       req, wr, rd;
  logic [1:0] adr;
  logic       wr_ctrl, wr_data, wr_prescale;
  logic       scroll_act, scroll_entry, tick_clr, tick;
  logic       unused_addr;

  assign adr         = wbs_address[1:0];
  assign unused_addr = ^wbs_address[ADDR_WIDTH-1:2];

  // The ack itself blocks a new request, so a held strobe is served every other cycle.
  assign req = wbs_cycle & wbs_strobe & ~ack_q;
  assign wr  = req & wbs_write;
  assign rd  = req & ~wbs_write;

  assign wr_ctrl     = wr && (adr == REG_CTRL);
  assign wr_data     = wr && (adr == REG_DATA);
  assign wr_prescale = wr && (adr == REG_PRESCALE);

  assign scroll_act   = ctrl_q.en && (ctrl_q.mode == MODE_SCROLL);
  assign scroll_entry = scroll_act && !scroll_q;
  assign tick_clr     = wr_prescale | wr_data | scroll_entry;

  bar_graph_ticker #(
    .WIDTH (DATA_WIDTH)
  ) u_ticker (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (tick_clr),
    .enable_i (scroll_act),
    .period_i (prescale_q),
    .tick_o   (tick)
  );

  always_comb begin
    pattern_d = pattern_q;
    if (wr_data) begin
      pattern_d = wbs_writedata[LED_COUNT-1:0];
    end else if (scroll_entry) begin
      pattern_d = data_q[LED_COUNT-1:0];
    end else if (tick) begin
      pattern_d = {pattern_q[LED_COUNT-2:0], pattern_q[LED_COUNT-1]};
    end
  end

  // Full-width compare: large DATA values saturate instead of wrapping.
  always_comb begin
    level_mask = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      level_mask[i] = (data_q > DATA_WIDTH'(i));
    end
  end

  always_comb begin
    base_pat = '0;
    if (ctrl_q.en) begin
      case (ctrl_q.mode)
        MODE_DIRECT: base_pat = data_q[LED_COUNT-1:0];
        MODE_LEVEL:  base_pat = level_mask;
        MODE_SCROLL: base_pat = pattern_q;
        default:     base_pat = '0;
      endcase
    end
  end

`ifdef BAR_GRAPH_PWM_EN
  logic [3:0] bright_q;
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic       wr_bright;

  assign wr_bright = wr && (adr == REG_BRIGHT);
  assign pwm_cnt_d = (pwm_cnt_q == 4'(PWM_PERIOD - 1)) ? 4'd0 : pwm_cnt_q + 4'd1;
  assign led_d     = (pwm_cnt_q < bright_q) ? base_pat : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      bright_q  <= BRIGHT_RESET;
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      if (wr_bright) begin
        bright_q <= wbs_writedata[3:0];
      end
    end
  end
`else
  assign led_d = base_pat;
`endif

  always_comb begin
    rd_mux = '0;
    case (adr)
      REG_CTRL:     rd_mux[CTRL_WIDTH-1:0] = ctrl_q;
      REG_DATA:     rd_mux = data_q;
      REG_PRESCALE: rd_mux = prescale_q;
      default: begin
`ifdef BAR_GRAPH_PWM_EN
        rd_mux[3:0] = bright_q;
`else
        rd_mux[LED_COUNT-1:0] = led_q;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      ctrl_q     <= '0;
      data_q     <= '0;
      prescale_q <= '0;
      pattern_q  <= '0;
      led_q      <= '0;
      scroll_q   <= 1'b0;
    end else begin
      ack_q     <= req;
      pattern_q <= pattern_d;
      led_q     <= led_d;
      scroll_q  <= scroll_act;
      if (rd) begin
        rdata_q <= rd_mux;
      end
      if (wr_ctrl) begin
        ctrl_q <= ctrl_t'(wbs_writedata[CTRL_WIDTH-1:0]);
      end
      if (wr_data) begin
        data_q <= wbs_writedata;
      end
      if (wr_prescale) begin
        prescale_q <= wbs_writedata;
      end
    end
  end

  assign wbs_ack      = ack_q;
  assign wbs_readdata = rdata_q;
  assign led          = led_q;

endmodule

// File: tb/tb_wb_bar_graph.sv
// Self-checking bench for wb_bar_graph: directed steps plus randomized traffic
// checked against an arithmetic model of the register map and LED patterns.
module tb_wb_bar_graph;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr, wdat;
  logic [15:0] rdat;
  logic        we, cyc, stb;
  logic        ack;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;

  logic [2:0]  m_ctrl;
  logic [15:0] m_data, m_pre;
  logic [3:0]  m_bright;

  always #5 clk = ~clk;

  wb_bar_graph #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .LED_COUNT  (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wbs_address   (adr),
    .wbs_writedata (wdat),
    .wbs_readdata  (rdat),
    .wbs_write     (we),
    .wbs_cycle     (cyc),
    .wbs_strobe    (stb),
    .wbs_ack       (ack),
    .led           (led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
    int k;
    int x;
    k = r % 8;
    x = int'(v);
    x = ((x << k) | (x >> (8 - k))) & 255;
    return x[7:0];
  endfunction

  function automatic logic [7:0] exp_pat(input int rot);
    int n;
    if (!m_ctrl[0]) return 8'h00;
    case (m_ctrl[2:1])
      2'd0: return m_data[7:0];
      2'd1: begin
        n = (m_data >= 16'd8) ? 8 : int'(m_data);
        return 8'((1 << n) - 1);
      end
      2'd2: return rotl8(m_data[7:0], rot);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] exp_reg(input logic [1:0] a);
    case (a)
      2'd0: return {13'b0, m_ctrl};
      2'd1: return m_data;
      2'd2: return m_pre;
`ifdef BAR_GRAPH_PWM_EN
      default: return {12'b0, m_bright};
`else
      default: return {8'b0, exp_pat(0)};
`endif
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl   = '0;
    m_data   = '0;
    m_pre    = '0;
    m_bright = 4'hF;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {14'b0, a}; wdat = d;
    @(negedge clk);
    chk("wr_ack", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    case (a)
      2'd0: m_ctrl = d[2:0];
      2'd1: m_data = d;
      2'd2: m_pre  = d;
      default: begin
`ifdef BAR_GRAPH_PWM_EN
        m_bright = d[3:0];
`endif
      end
    endcase
  endtask

  task automatic read_chk(input logic [1:0] a, input string tag);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {14'b0, a};
    @(negedge clk);
    chk("rd_ack", 32'(ack), 32'd1);
    chk(tag, 32'(rdat), 32'(exp_reg(a)));
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic write_chk(input logic [1:0] a, input logic [15:0] d, input string tag);
    write_reg(a, d);
    @(negedge clk);
    chk(tag, 32'(led), 32'(exp_pat(0)));
  endtask

  // After a DATA write the pattern holds for PRESCALE+1 samples per rotation step.
  task automatic scroll_run(input logic [15:0] d, input int cycles, input string tag);
    write_reg(2'd1, d);
    for (int j = 1; j <= cycles; j++) begin
      @(negedge clk);
      chk(tag, 32'(led), 32'(exp_pat((j - 1) / (int'(m_pre) + 1))));
    end
  endtask

  initial begin
    logic [15:0] v;
    int          pulses;
    int          consec;
    int          prev;
    int          op;
    int          on_cnt;
    int          bad;

    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_rdata", 32'(rdat), 32'd0);
    reset = 1'b0;

    // Reset register values
    for (int a = 0; a < 4; a++) read_chk(2'(a), "rst_reg");
    chk("rst_led2", 32'(led), 32'd0);

    // Direct mode
    write_chk(2'd0, 16'h0001, "dir_en");
    write_chk(2'd1, 16'h00A5, "dir_a5");
    write_chk(2'd0, 16'h0000, "dir_off");

    // Level mode, including saturation without wrap
    write_chk(2'd0, 16'h0003, "lvl_en");
    write_chk(2'd1, 16'h0000, "lvl_0");
    write_chk(2'd1, 16'h0003, "lvl_3");
    write_chk(2'd1, 16'h0008, "lvl_8");
    write_chk(2'd1, 16'h1234, "lvl_big");
    write_chk(2'd1, 16'h0100, "lvl_256");
    write_chk(2'd1, 16'h0007, "lvl_7");

    // Scroll mode
    write_reg(2'd2, 16'd3);
    write_reg(2'd0, 16'h0005);
    scroll_run(16'h0081, 12, "scr_81");
    scroll_run(16'h0001, 10, "scr_restart");
    for (int k = 0; k < 4; k++) begin
      write_reg(2'd2, 16'($urandom_range(0, 4)));
      scroll_run(16'($urandom_range(1, 255)), 3 * (int'(m_pre) + 1) + 2, "scr_rand");
    end

    // Held strobe: one ack every other cycle
    write_chk(2'd0, 16'h0003, "hold_setup");
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'd1;
    pulses = 0; consec = 0; prev = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack) begin
        pulses++;
        if (prev != 0) consec++;
        chk("hold_rdata", 32'(rdat), 32'(m_data));
      end
      prev = int'(ack);
    end
    cyc = 1'b0; stb = 1'b0;
    chk("hold_pulses", 32'(pulses), 32'd5);
    chk("hold_consec", 32'(consec), 32'd0);
    @(negedge clk);

    // Randomized traffic in the non-scrolling modes
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          v = 16'($urandom);
          if (v[2:1] == 2'd2) v[2:1] = 2'd3;
          write_chk(2'd0, v, "rnd_ctrl");
        end
        1: write_chk(2'd1, 16'($urandom), "rnd_data");
        2: write_chk(2'd1, 16'($urandom_range(0, 10)), "rnd_small");
        default: read_chk(2'($urandom_range(0, 3)), "rnd_read");
      endcase
    end
    write_reg(2'd2, 16'($urandom));
    read_chk(2'd2, "rnd_pre");

`ifdef BAR_GRAPH_PWM_EN
    write_reg(2'd0, 16'h0001);
    write_reg(2'd1, 16'h00FF);
    for (int b = 0; b < 3; b++) begin
      v = (b == 0) ? 16'd5 : ((b == 1) ? 16'd0 : 16'd15);
      write_reg(2'd3, v);
      read_chk(2'd3, "pwm_bright");
      on_cnt = 0; bad = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (led == 8'hFF) on_cnt++;
        else if (led != 8'h00) bad++;
      end
      chk("pwm_on", 32'(on_cnt), 32'(4 * int'(v)));
      chk("pwm_levels", 32'(bad), 32'd0);
    end
`endif

    // Reset during a pending read
    write_reg(2'd1, 16'h5A5A);
    write_reg(2'd2, 16'd7);
    write_reg(2'd0, 16'h0001);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'd1; reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_led", 32'(led), 32'd0);
    reset = 1'b0; cyc = 1'b0; stb = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_ack2", 32'(ack), 32'd0);
    for (int a = 0; a < 4; a++) read_chk(2'(a), "rst_mid_reg");
    chk("rst_mid_led2", 32'(led), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_bar_graph.md
Name: wb_bar_graph

Overview:
- Wishbone slave that drives the LED bar graph. It sits directly downstream of the 1-master/2-slave shared-bus intercon and occupies one strobe/cycle/ack slot.
- Holds a small register file with control, data and prescaler registers, and generates the LED pattern in one of three modes: direct, level meter, scroll.
- Registered single-cycle ack, matching the classic (non-pipelined) Wishbone handshake the intercon expects.

Parameters:
- ADDR_WIDTH, 16, Wishbone address width. Only bits [1:0] are decoded.
- DATA_WIDTH, 16, Wishbone data width.
- LED_COUNT, 8, number of LED outputs (2..DATA_WIDTH).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wbs_address  in  ADDR_WIDTH  register address; word index is address[1:0]
- wbs_writedata  in  DATA_WIDTH  write data
- wbs_readdata  out  DATA_WIDTH  read data, valid while wbs_ack=1
- wbs_write  in  1  1 = write, 0 = read
- wbs_cycle  in  1  bus cycle in progress
- wbs_strobe  in  1  transfer strobe
- wbs_ack  out  1  acknowledge
- led  out  LED_COUNT  LED drive; bit 0 is the bottom of the bar

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - CTRL = 0, DATA = 0, PRESCALE = 0, tick counter = 0.
  - wbs_ack = 0, wbs_readdata = 0, led = 0.
  - BRIGHT = 15 (with the optional feature only).
- Register map (address[1:0]):
  - 0 CTRL (RW): [0] enable, [2:1] mode (0 direct, 1 level, 2 scroll, 3 reserved, which behaves as all LEDs off). Other bits read 0.
  - 1 DATA (RW): full DATA_WIDTH.
  - 2 PRESCALE (RW): full DATA_WIDTH.
  - 3 BRIGHT/STATUS: see Optional Feature.
- Handshake:
  - A request is cycle & strobe & !wbs_ack.
  - wbs_ack = 1 on the clock edge after the request is seen, then 0 on the following edge. Ack is a one-cycle pulse, so a held strobe produces ack every second cycle.
  - A write takes effect on the same edge that raises ack.
  - wbs_readdata is registered with ack. It holds its last value when ack is 0.
  - If strobe drops before ack, ack is still issued; the master ignores it.
- Pattern generation (registered; led updates one cycle after the register or tick change):
  - enable = 0: led = 0.
  - Direct mode: led = DATA[LED_COUNT-1:0].
  - Level mode: n = min(DATA, LED_COUNT). The lowest n LEDs are on. DATA=0 gives all off; DATA >= LED_COUNT gives all on, and no wrap of large values is permitted.
  - Scroll mode: an internal pattern register loads DATA[LED_COUNT-1:0] when the mode is entered or DATA is written. On every tick it rotates left by 1 (MSB to bit 0).
  - Tick generation: the tick counter counts 0..PRESCALE and pulses tick on wrap, giving a period of PRESCALE+1 clocks. PRESCALE=0 gives a tick every clock.
  - Writing PRESCALE clears the tick counter.
  - The counter runs only while enable=1 and mode=2.
- Reset mid-transaction: ack is dropped immediately at the edge and the pending request is discarded; the master must retry.

Optional Feature:
- Macro: BAR_GRAPH_PWM_EN.
- With the macro defined:
  - Address 3 is BRIGHT (RW, bits [3:0], reset 15).
  - A free-running PWM counter runs 0..14 and wraps, giving a period of 15.
  - led = pattern when pwm_cnt < BRIGHT, else 0. BRIGHT=0 is always off; BRIGHT=15 is always on.
- Without the macro:
  - Address 3 is read-only STATUS, returning {0, current led value}. Writes are acked and ignored.
  - No PWM counter exists, and led = pattern.

Decomposition:
- Shared package wb_bar_graph_pkg holds:
  - register index constants REG_CTRL=0, REG_DATA=1, REG_PRESCALE=2, REG_BRIGHT=3;
  - mode constants MODE_DIRECT=0, MODE_LEVEL=1, MODE_SCROLL=2;
  - the CTRL bit positions.
- One sub-module is natural: bar_graph_ticker, the prescaler/tick generator with clear and enable inputs. It is reusable for other timed peripherals.

Test Plan:
1. Reset, then read all 4 registers. Expect CTRL=0, DATA=0, PRESCALE=0, addr3 = 0x000F with the macro or 0x0000 without. Expect led=0, and ack exactly 1 cycle after each strobe.
2. Write CTRL=0x0001 and DATA=0x00A5. Expect led=0xA5 one cycle after the DATA ack. Then write CTRL=0x0000 and expect led=0x00.
3. Level mode (CTRL=0x0003), DATA = 0, 3, 8, 0x1234 in turn. Expect led = 0x00, 0x07, 0xFF, 0xFF.
4. Scroll mode (CTRL=0x0005), DATA=0x81, PRESCALE=3. Expect led 0x81 → 0x03 → 0x06 with exactly 4 clocks between changes. Then rewrite DATA=0x01 and expect led=0x01 with the phase restarted.
5. Hold cycle/strobe high for 10 clocks on a read. Expect 5 single-cycle ack pulses, never two consecutive.
6. With BAR_GRAPH_PWM_EN: direct 0xFF, BRIGHT=5. Expect led=0xFF for 5 of every 15 clocks. BRIGHT=0 gives always 0; BRIGHT=15 gives always 0xFF. Assert reset during a pending read and expect ack=0 and all registers at reset values.
